// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin pick of the next runnable hardware thread, with a delayed PC write select.
module thread_scheduler #(
  parameter int NUM_THREADS = 5,
  parameter int TID_W = 3,
  parameter int WB_DELAY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic                   stall_req,
  input  logic [TID_W-1:0]       stall_tid,
  input  logic                   wake_req,
  input  logic [TID_W-1:0]       wake_tid,
  output logic [TID_W-1:0]       sel_read,
  output logic                   fetch_valid,
  output logic [TID_W-1:0]       sel_write,
  output logic                   pc_en,
  output logic                   idle
);
  logic [TID_W-1:0] last_tid, pick;
  logic [TID_W:0] cand;
  logic [NUM_THREADS-1:0] blocked, blocked_nxt, runnable;
  logic [WB_DELAY-1:0] vld, vld_nxt;
  logic [WB_DELAY-1:0][TID_W-1:0] tid_q, tid_nxt;
  assign runnable = thread_enable & ~blocked;
  // Scan farthest-first so the nearest runnable thread after last_tid wins.
  always_comb begin
    pick = last_tid;
    cand = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand = {1'b0, last_tid} + (TID_W+1)'(k);
      if (cand >= (TID_W+1)'(NUM_THREADS)) cand = cand - (TID_W+1)'(NUM_THREADS);
      if (runnable[cand[TID_W-1:0]]) pick = cand[TID_W-1:0];
    end
  end
  // Outputs are gated by reset so they read as cleared while reset is held.
  assign fetch_valid = reset & (|runnable);
  assign idle = ~fetch_valid;
  assign sel_read = fetch_valid ? pick : (reset ? last_tid : '0);
  assign sel_write = tid_q[WB_DELAY-1];
  assign pc_en = vld[WB_DELAY-1] & en;
  always_comb begin
    blocked_nxt = blocked;
    for (int i = 0; i < NUM_THREADS; i++)
      blocked_nxt[i] = (wake_req && wake_tid == TID_W'(i)) ? 1'b0 :
                       (stall_req && stall_tid == TID_W'(i)) ? 1'b1 : blocked[i];
  end
  // Shift on advance, then invalidate flushed or stalled entries, including the new head.
  always_comb begin
    vld_nxt = vld;
    tid_nxt = tid_q;
    if (en) begin
      for (int i = 1; i < WB_DELAY; i++) begin
        vld_nxt[i] = vld[i-1];
        tid_nxt[i] = tid_q[i-1];
      end
      vld_nxt[0] = fetch_valid;
      tid_nxt[0] = sel_read;
    end
    for (int i = 0; i < WB_DELAY; i++)
      if (flush || (stall_req && tid_nxt[i] == stall_tid)) vld_nxt[i] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_tid <= TID_W'(NUM_THREADS-1);
      blocked <= '0;
      vld <= '0;
      tid_q <= '0;
    end else begin
      blocked <= blocked_nxt;
      vld <= vld_nxt;
      tid_q <= tid_nxt;
      if (en && fetch_valid) last_tid <= pick;
    end
endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed and randomized checks against a queue-level round-robin model.
module tb_thread_scheduler;
  localparam int N = 5, W = 3, WB = 1;
  logic clk = 0, reset, en, flush, stall_req, wake_req;
  logic [N-1:0] thread_enable;
  logic [W-1:0] stall_tid, wake_tid, sel_read, sel_write;
  logic fetch_valid, pc_en, idle;
  int checks = 0, failures = 0;
  int m_last;
  bit m_blk[N];
  bit m_v[WB];
  int m_t[WB];

  always #5 clk = ~clk;

  thread_scheduler #(.NUM_THREADS(N), .TID_W(W), .WB_DELAY(WB)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .thread_enable(thread_enable),
    .stall_req(stall_req), .stall_tid(stall_tid), .wake_req(wake_req), .wake_tid(wake_tid),
    .sel_read(sel_read), .fetch_valid(fetch_valid), .sel_write(sel_write), .pc_en(pc_en), .idle(idle));

  function automatic int m_pick();
    for (int k = 1; k <= N; k++) begin
      int t = (m_last + k) % N;
      if (thread_enable[t] && !m_blk[t]) return t;
    end
    return -1;
  endfunction

  function automatic logic [8:0] expv();
    int p = m_pick();
    int sr = (p >= 0) ? p : m_last;
    return {3'(sr), p >= 0, p < 0, 3'(m_t[WB-1]), m_v[WB-1] & en};
  endfunction

  function automatic logic [8:0] got();
    return {sel_read, fetch_valid, idle, sel_write, pc_en};
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    foreach (m_blk[i]) m_blk[i] = 0;
    foreach (m_v[i]) begin m_v[i] = 0; m_t[i] = 0; end
  endtask

  task automatic quiet();
    en = 1; flush = 0; stall_req = 0; wake_req = 0; stall_tid = 0; wake_tid = 0;
  endtask

  task automatic tick();
    int p, sr;
    @(posedge clk);
    p = m_pick();
    sr = (p >= 0) ? p : m_last;
    if (en) begin
      for (int i = WB - 1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_t[i] = m_t[i-1]; end
      m_v[0] = p >= 0;
      m_t[0] = sr;
      if (p >= 0) m_last = p;
    end
    foreach (m_v[i]) if (flush || (stall_req && m_t[i] == int'(stall_tid))) m_v[i] = 0;
    if (stall_req && stall_tid < N) m_blk[stall_tid] = 1;
    if (wake_req && wake_tid < N) m_blk[wake_tid] = 0;
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    @(posedge clk);
    #2 reset = 1;
  endtask

  task automatic test_reset();
    quiet();
    thread_enable = '1;
    reset = 0;
    model_reset();
    #2;
    checks++;
    if (got() !== 9'b000_0_1_000_0) begin failures++; $display("FAIL reset_vals got=%b exp=%b", got(), 9'b000_0_1_000_0); end
    @(posedge clk);
    #2 reset = 1;
  endtask

  task automatic test_round_robin();
    int seq[7] = '{0, 1, 2, 3, 4, 0, 1};
    thread_enable = '1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, got(), expv()); end
      checks++;
      if (sel_read !== 3'(seq[c])) begin failures++; $display("FAIL rr_seq c=%0d got=%0d exp=%0d", c, sel_read, seq[c]); end
      if (c > 0) begin
        checks++;
        if ({sel_write, pc_en} !== {3'(seq[c-1]), 1'b1}) begin failures++; $display("FAIL rr_write c=%0d got=%0d/%b exp=%0d/1", c, sel_write, pc_en, seq[c-1]); end
      end
      tick();
    end
  endtask

  task automatic test_mask();
    int seq[5] = '{0, 2, 4, 0, 2};
    thread_enable = 5'b10101;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 5) thread_enable = 5'b01000;
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL mask_model c=%0d got=%h exp=%h", c, got(), expv()); end
      checks++;
      if ({sel_read, fetch_valid} !== {3'(c < 5 ? seq[c] : 3), 1'b1}) begin failures++; $display("FAIL mask_seq c=%0d got=%0d/%b exp=%0d/1", c, sel_read, fetch_valid, c < 5 ? seq[c] : 3); end
      tick();
    end
  endtask

  task automatic test_stall_wake();
    int seq[12] = '{0, 1, 2, 3, 4, 0, 1, 3, 4, 0, 1, 2};
    thread_enable = '1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      stall_req = (c == 2); stall_tid = 2;
      wake_req = (c == 8); wake_tid = 2;
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL stall_model c=%0d got=%h exp=%h", c, got(), expv()); end
      checks++;
      if (sel_read !== 3'(seq[c])) begin failures++; $display("FAIL stall_seq c=%0d got=%0d exp=%0d", c, sel_read, seq[c]); end
      if (c == 3) begin
        checks++;
        if ({sel_write, pc_en} !== {3'd2, 1'b0}) begin failures++; $display("FAIL stall_squash got=%0d/%b exp=2/0", sel_write, pc_en); end
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_same_tid();
    logic [3:0] exp_rf[3] = '{4'b001_1, 4'b001_0, 4'b001_1};
    thread_enable = 5'b00010;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      stall_req = (c < 2); stall_tid = 1;
      wake_req = (c == 1); wake_tid = 1;
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL same_model c=%0d got=%h exp=%h", c, got(), expv()); end
      checks++;
      if ({sel_read, fetch_valid} !== exp_rf[c]) begin failures++; $display("FAIL same_tid c=%0d got=%b exp=%b", c, {sel_read, fetch_valid}, exp_rf[c]); end
      tick();
    end
    quiet();
  endtask

  task automatic test_idle();
    logic [W-1:0] prev = '0;
    thread_enable = '1;
    for (int c = 0; c < 8; c++) begin
      thread_enable = (c >= 3 && c < 6) ? '0 : '1;
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL idle_model c=%0d got=%h exp=%h", c, got(), expv()); end
      if (c == 2) prev = sel_read;
      if (c >= 4 && c < 6) begin
        checks++;
        if ({idle, fetch_valid, pc_en} !== 3'b100) begin failures++; $display("FAIL idle_out c=%0d got=%b exp=100", c, {idle, fetch_valid, pc_en}); end
      end
      if (c == 6) begin
        checks++;
        if (sel_read !== 3'((int'(prev) + 1) % N)) begin failures++; $display("FAIL idle_resume got=%0d exp=%0d", sel_read, (int'(prev) + 1) % N); end
      end
      tick();
    end
  endtask

  task automatic test_en_low();
    logic [W-1:0] held = '0;
    thread_enable = '1;
    for (int c = 0; c < 7; c++) begin
      en = !(c >= 2 && c < 5);
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL enlow_model c=%0d got=%h exp=%h", c, got(), expv()); end
      if (c == 2) held = sel_read;
      if (c > 2 && c < 5) begin
        checks++;
        if ({sel_read, pc_en} !== {held, 1'b0}) begin failures++; $display("FAIL enlow_hold c=%0d got=%0d/%b exp=%0d/0", c, sel_read, pc_en, held); end
      end
      tick();
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    thread_enable = '1;
    for (int c = 0; c < 3; c++) tick();
    reset = 0;
    #1;
    checks++;
    if (got() !== 9'b000_0_1_000_0) begin failures++; $display("FAIL reset_mid got=%b exp=%b", got(), 9'b000_0_1_000_0); end
    model_reset();
    @(posedge clk);
    #2 reset = 1;
    @(negedge clk);
    checks++;
    if ({sel_read, fetch_valid, pc_en} !== 5'b000_1_0) begin failures++; $display("FAIL reset_pick got=%b exp=00010", {sel_read, fetch_valid, pc_en}); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom % 4) != 0;
      flush = ($urandom % 8) == 0;
      stall_req = ($urandom % 4) == 0; stall_tid = W'($urandom % 8);
      wake_req = ($urandom % 3) == 0; wake_tid = W'($urandom % 8);
      thread_enable = N'($urandom);
      @(negedge clk);
      checks++;
      if (got() !== expv()) begin failures++; $display("FAIL rand_model c=%0d got=%h exp=%h", c, got(), expv()); end
      tick();
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_mask();
    test_stall_wake();
    test_same_tid();
    test_idle();
    test_en_low();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Round-robin hardware-thread scheduler for the five-context barrel core. Each cycle it picks the next runnable thread and drives the read select of the PC repository, so fetch uses that thread's PC. It also delays each pick through a short pipeline so the PC repository receives a matching write select and write enable when the updated PC comes back. Per-thread run-enable and stall/wake tracking keep blocked threads out of the rotation.

## Interface
- NUM_THREADS, 5, number of hardware contexts (2..8)
- TID_W, 3, thread-ID width; fixed at 3
- WB_DELAY, 1, number of advancing cycles from a fetch pick to its PC write (>=1)

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- en  in  1  pipeline advance; 0 freezes all state
- flush  in  1  invalidates every in-flight delay-line entry
- thread_enable  in  NUM_THREADS  software run mask; bit i=1 allows thread i to run
- stall_req  in  1  blocks thread stall_tid
- stall_tid  in  TID_W  thread to block
- wake_req  in  1  unblocks thread wake_tid
- wake_tid  in  TID_W  thread to unblock
- sel_read  out  TID_W  thread whose PC is fetched this cycle
- fetch_valid  out  1  sel_read names a runnable thread
- sel_write  out  TID_W  thread whose PC is written this cycle
- pc_en  out  1  PC write enable for sel_write
- idle  out  1  no thread is runnable

## Operation
- State:
  - last_tid register, reset value NUM_THREADS-1.
  - blocked[NUM_THREADS-1:0], reset value all 0.
  - Delay line of WB_DELAY entries, each {valid, tid}; reset value all {0,0}.
- Runnable mask: runnable[i] = thread_enable[i] & ~blocked[i], using the registered blocked mask.
- Pick (combinational):
  - Search order is last_tid+1, last_tid+2, …, last_tid, with wrap from NUM_THREADS-1 to 0.
  - pick is the first runnable thread in that order.
  - If only last_tid is runnable, it is picked again.
- fetch_valid = |runnable; idle = ~fetch_valid.
- sel_read = pick when fetch_valid=1, otherwise last_tid.
- Edge with en=1:
  - If fetch_valid=1, last_tid <= pick.
  - The delay line shifts; the head loads {fetch_valid, sel_read}.
- Edge with en=0: last_tid and the delay line hold. blocked still updates.
- Squash:
  - While stall_req=1, every delay-line entry whose tid equals stall_tid has its valid bit cleared on the edge.
  - This includes the entry being loaded into the head, so a stalled thread's PC never advances.
- Flush: flush=1 clears all valid bits on the edge, including the head entry being loaded. flush has priority over the shift.
- blocked update on each edge:
  - stall_req sets blocked[stall_tid].
  - wake_req clears blocked[wake_tid].
  - If both requests name the same tid, wake wins.
  - Requests with tid >= NUM_THREADS are ignored.
- Outputs from the delay-line tail: sel_write = tail.tid; pc_en = tail.valid & en.

## Timing
- Reset values (asynchronous, while reset=0):
  - sel_read=0, fetch_valid=0, idle=1, sel_write=0, pc_en=0.
  - With all threads enabled, the first pick after reset is thread 0.
- Fetch latency: zero. sel_read reflects the current-cycle runnable mask and last_tid.
- Write latency: a pick made on advancing cycle N appears on sel_write/pc_en on advancing cycle N+WB_DELAY.
- Stall/wake latency: takes effect on runnable one cycle after the request.
  - With WB_DELAY=1, the squash still catches a same-cycle fetch of the stalled thread.
- en low: outputs are frozen except pc_en, which is forced to 0. No pick is consumed.
- Reset asserted mid-operation: all state clears within the same cycle. In-flight entries are lost and produce no pc_en.
- All threads disabled: bubbles enter the delay line; pc_en drops to 0 after WB_DELAY advancing cycles.

## Test plan
- Reset release, thread_enable=5'b11111, en=1 -> sel_read sequence 0,1,2,3,4,0,1; sel_write lags by one cycle with pc_en=1 throughout.
- thread_enable=5'b10101 -> sel_read sequence 0,2,4,0,2; thread_enable=5'b01000 -> sel_read=3 on every cycle, fetch_valid=1.
- stall_req with stall_tid=2 in the cycle sel_read=2 -> the next cycle shows pc_en=0 for that slot and thread 2 is skipped (order 3,4,0,1,3); wake_req with wake_tid=2 -> thread 2 rejoins from its next round-robin turn.
- stall_req and wake_req both naming tid 1 while blocked[1]=1 -> thread 1 is unblocked on the next cycle.
- thread_enable=0 -> idle=1, fetch_valid=0, pc_en=0 after 1 cycle; re-enabling all threads resumes at last_tid+1.
- en=0 for 3 cycles mid-sequence -> sel_read holds and pc_en=0; reset pulsed low mid-sequence -> outputs return to 0 immediately and the next pick is 0.
